mpf_vtp_csr_responder: RTL

//  Responder (slave) end of the VTP generic CSR request channel.
//  - Decodes 64-bit CSR index requests issued by the MMIO front end.
//  - Owns the VTP control registers, the invalidation request handshake to the translation

---
 rtl/mpf_vtp_csr_responder_if.sv | 14 +
 rtl/mpf_vtp_csr_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/mpf_vtp_csr_responder_if.sv
// CSR request/response channel between the MMIO front end (master) and a CSR responder (slave).
interface mpf_vtp_csr_responder_if #(parameter int IDX_W = 6);
  logic [IDX_W-1:0] csr_req_idx;
  logic             rd_req_en;
  logic             wr_req_en;
  logic [63:0]      wr_data;
  logic             rd_rsp_valid;
  logic [63:0]      rd_data;

  modport master (output csr_req_idx, rd_req_en, wr_req_en, wr_data,
                  input  rd_rsp_valid, rd_data);
  modport slave  (input  csr_req_idx, rd_req_en, wr_req_en, wr_data,
                  output rd_rsp_valid, rd_data);
endinterface

// File: rtl/mpf_vtp_csr_responder.sv
// VTP CSR responder: control registers, invalidation handshake and hit/miss counters.
// Reads return one cycle after the request; writes land on the next clock edge.
module mpf_vtp_csr_responder #(
  parameter logic [63:0] VTP_UUID_LO   = 64'h0,
  parameter logic [63:0] VTP_UUID_HI   = 64'h0,
  parameter int          CSR_IDX_WIDTH = 6,
  parameter int          CNT_WIDTH     = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  mpf_vtp_csr_responder_if.slave csr,
  input  logic [63:0] dfh_value,
  output logic        vtp_enable,
  output logic [63:0] pt_paddr,
  output logic        inval_valid,
  output logic [63:0] inval_vaddr,
  input  logic        inval_ready,
  input  logic        walk_busy,
  input  logic        evt_hit,
  input  logic        evt_miss
);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_DFH    = CSR_IDX_WIDTH'(0);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_UUIDL  = CSR_IDX_WIDTH'(1);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_UUIDH  = CSR_IDX_WIDTH'(2);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_MODE   = CSR_IDX_WIDTH'(3);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_PTP    = CSR_IDX_WIDTH'(4);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_INVAL  = CSR_IDX_WIDTH'(5);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_STATUS = CSR_IDX_WIDTH'(6);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_HIT    = CSR_IDX_WIDTH'(7);
  localparam logic [CSR_IDX_WIDTH-1:0] IDX_MISS   = CSR_IDX_WIDTH'(8);

  logic [CSR_IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0]     hit_cnt, miss_cnt;
  logic [63:0]              rd_mux;
  logic                     inval_overflow;
  logic                     wr_mode, wr_ptp, wr_inval, wr_status, cnt_clr, xfer;

  assign idx       = csr.csr_req_idx;
  assign wr_mode   = csr.wr_req_en && (idx == IDX_MODE);
  assign wr_ptp    = csr.wr_req_en && (idx == IDX_PTP);
  assign wr_inval  = csr.wr_req_en && (idx == IDX_INVAL);
  assign wr_status = csr.wr_req_en && (idx == IDX_STATUS);
  assign cnt_clr   = wr_mode && csr.wr_data[1];
  assign xfer      = inval_valid && inval_ready;

  // Read mux sees pre-write state, so a simultaneous write never leaks into the response.
  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_DFH:    rd_mux = dfh_value;
      IDX_UUIDL:  rd_mux = VTP_UUID_LO;
      IDX_UUIDH:  rd_mux = VTP_UUID_HI;
      IDX_MODE:   rd_mux = {63'b0, vtp_enable};
      IDX_PTP:    rd_mux = pt_paddr;
      IDX_STATUS: rd_mux = {61'b0, inval_overflow, inval_valid, walk_busy};
      IDX_HIT:    rd_mux = 64'(hit_cnt);
      IDX_MISS:   rd_mux = 64'(miss_cnt);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr.rd_rsp_valid <= 1'b0;
      csr.rd_data      <= '0;
      vtp_enable       <= 1'b0;
      pt_paddr         <= '0;
      inval_valid      <= 1'b0;
      inval_vaddr      <= '0;
      inval_overflow   <= 1'b0;
      hit_cnt          <= '0;
      miss_cnt         <= '0;
    end else begin
      csr.rd_rsp_valid <= csr.rd_req_en;
      if (csr.rd_req_en) csr.rd_data <= rd_mux;
      if (wr_mode) vtp_enable <= csr.wr_data[0];
      if (wr_ptp)  pt_paddr   <= csr.wr_data;

      // A new request is taken only into an empty slot or one being drained this cycle.
      if (wr_inval && (!inval_valid || xfer)) begin
        inval_valid <= 1'b1;
        inval_vaddr <= csr.wr_data;
      end else if (xfer) begin
        inval_valid <= 1'b0;
      end

      if (wr_status)                             inval_overflow <= 1'b0;
      else if (wr_inval && inval_valid && !xfer) inval_overflow <= 1'b1;

      if (cnt_clr)                    hit_cnt <= '0;
      else if (evt_hit && ~&hit_cnt)  hit_cnt <= hit_cnt + CNT_WIDTH'(1);
      if (cnt_clr)                    miss_cnt <= '0;
      else if (evt_miss && ~&miss_cnt) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end
endmodule
